// File: rtl/usb_fifo_drain_arbiter.sv
// rtl/usb_fifo_drain_arbiter.sv - round-robin drain arbiter for per-port receive FIFOs with 2-entry skid output
// Optional build macro: USB_ARB_STATS_EN adds the stat_grants / stat_words counters.
module usb_fifo_drain_arbiter #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 64,
   parameter int GAP_CYCLES = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_PORTS-1:0]             port_enable,
   input  logic [NUM_PORTS-1:0]             fifo_empty,
   output logic [NUM_PORTS-1:0]             fifo_rd_en,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  fifo_rd_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [DATA_WIDTH-1:0]            out_data,
   output logic [$clog2(NUM_PORTS)-1:0]     out_port,
   output logic                             out_first,
   output logic                             busy
`ifdef USB_ARB_STATS_EN
   ,
   output logic [15:0]                      stat_grants,
   output logic [31:0]                      stat_words
`endif
);

   localparam int PW       = $clog2(NUM_PORTS);
   localparam int BW       = $clog2(MAX_BURST + 1);
   localparam int GW       = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_FLUSH = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   state_t                state;
   state_t                state_nxt;

   logic [PW-1:0]         grant;
   logic [PW-1:0]         last_grant;
   logic [BW-1:0]         burst_cnt;
   logic [GW-1:0]         gap_cnt;
   logic                  inflight;
   logic                  inflight_first;

   logic [NUM_PORTS-1:0]  req;
   logic                  pick_valid;
   logic [PW-1:0]         pick_port;
   logic [PW:0]           pick_sum;

   logic                  grant_ready;
   logic                  burst_done;
   logic                  room;
   logic                  rd_go;
   logic                  grant_evt;
   logic                  flush_exit;

   logic [DATA_WIDTH-1:0] skid_data  [2];
   logic [PW-1:0]         skid_port  [2];
   logic                  skid_first [2];
   logic [1:0]            skid_count;
   logic [DATA_WIDTH-1:0] push_data;
   logic                  push;
   logic                  pop;

   assign req         = port_enable & ~fifo_empty;
   assign grant_ready = port_enable[grant] && !fifo_empty[grant];
   assign burst_done  = (burst_cnt == BW'(MAX_BURST));
   // Room counts words already in the skid plus the one arriving from last cycle's read.
   assign room        = ((3'(skid_count) + 3'(inflight)) < 3'd2);
   assign rd_go       = (state == S_DRAIN) && grant_ready && !burst_done && room;
   assign grant_evt   = (state == S_IDLE) && pick_valid;
   assign flush_exit  = (state == S_FLUSH) && !inflight && (skid_count == 2'd0);

   assign push        = inflight;
   assign pop         = out_valid && out_ready;

   assign out_valid   = (skid_count != 2'd0);
   assign out_data    = skid_data[0];
   assign out_port    = skid_port[0];
   assign out_first   = skid_first[0];

   // Round-robin search starting one past the last served port, wrapping modulo NUM_PORTS.
   always_comb begin
      pick_valid = 1'b0;
      pick_port  = '0;
      pick_sum   = '0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         pick_sum = {1'b0, last_grant} + (PW+1)'(i);
         if (pick_sum >= (PW+1)'(NUM_PORTS)) begin
            pick_sum = pick_sum - (PW+1)'(NUM_PORTS);
         end
         if (!pick_valid && req[pick_sum[PW-1:0]]) begin
            pick_valid = 1'b1;
            pick_port  = pick_sum[PW-1:0];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode plus read strobe and busy outputs.
   always_comb begin
      state_nxt  = state;
      fifo_rd_en = '0;
      busy       = (state != S_IDLE);
      if (rd_go) begin
         fifo_rd_en = {{(NUM_PORTS-1){1'b0}}, 1'b1} << grant;
      end
      case (state)
         S_IDLE: begin
            if (pick_valid) begin
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (burst_done || !grant_ready) begin
               state_nxt = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (flush_exit) begin
               state_nxt = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
            end
         end
         S_GAP: begin
            if (gap_cnt == GW'(GAP_LAST)) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Grant bookkeeping: burst length, read-in-flight flag, gap timer, last served port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant          <= '0;
         last_grant     <= PW'(NUM_PORTS - 1);
         burst_cnt      <= '0;
         gap_cnt        <= '0;
         inflight       <= 1'b0;
         inflight_first <= 1'b0;
      end else begin
         if (grant_evt) begin
            grant     <= pick_port;
            burst_cnt <= '0;
         end else if (rd_go) begin
            burst_cnt <= burst_cnt + 1'b1;
         end
         inflight       <= rd_go;
         inflight_first <= rd_go && (burst_cnt == '0);
         if (flush_exit) begin
            last_grant <= grant;
         end
         if (state == S_GAP) begin
            gap_cnt <= gap_cnt + 1'b1;
         end else begin
            gap_cnt <= '0;
         end
      end
   end

   // Select the granted port's read data; grant cannot change while a read is in flight.
   always_comb begin
      push_data = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grant == PW'(i)) begin
            push_data = fifo_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Two-entry in-order skid; entry 0 is the head that drives out_*.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_count <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            skid_data[i]  <= '0;
            skid_port[i]  <= '0;
            skid_first[i] <= 1'b0;
         end
      end else begin
         case ({push, pop})
            2'b10: begin
               if (skid_count == 2'd0) begin
                  skid_data[0]  <= push_data;
                  skid_port[0]  <= grant;
                  skid_first[0] <= inflight_first;
               end else begin
                  skid_data[1]  <= push_data;
                  skid_port[1]  <= grant;
                  skid_first[1] <= inflight_first;
               end
               skid_count <= skid_count + 2'd1;
            end
            2'b01: begin
               skid_data[0]  <= skid_data[1];
               skid_port[0]  <= skid_port[1];
               skid_first[0] <= skid_first[1];
               skid_count    <= skid_count - 2'd1;
            end
            2'b11: begin
               if (skid_count == 2'd1) begin
                  skid_data[0]  <= push_data;
                  skid_port[0]  <= grant;
                  skid_first[0] <= inflight_first;
               end else begin
                  skid_data[0]  <= skid_data[1];
                  skid_port[0]  <= skid_port[1];
                  skid_first[0] <= skid_first[1];
                  skid_data[1]  <= push_data;
                  skid_port[1]  <= grant;
                  skid_first[1] <= inflight_first;
               end
            end
            default: begin
               skid_count <= skid_count;
            end
         endcase
      end
   end

`ifdef USB_ARB_STATS_EN
   // Saturating grant and accepted-word counters, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_grants <= '0;
         stat_words  <= '0;
      end else begin
         if (grant_evt && (stat_grants != '1)) begin
            stat_grants <= stat_grants + 16'd1;
         end
         if (pop && (stat_words != '1)) begin
            stat_words <= stat_words + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_usb_fifo_drain_arbiter.sv
// tb/tb_usb_fifo_drain_arbiter.sv - self-checking bench for usb_fifo_drain_arbiter
module tb_usb_fifo_drain_arbiter;

   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int MB  = 4;
   localparam int GAP = 2;
   localparam int PW  = $clog2(N);

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      port_enable;
   logic [N-1:0]      fifo_empty;
   logic [N-1:0]      fifo_rd_en;
   logic [N*DW-1:0]   fifo_rd_data;
   logic              out_valid;
   logic              out_ready;
   logic [DW-1:0]     out_data;
   logic [PW-1:0]     out_port;
   logic              out_first;
   logic              busy;
`ifdef USB_ARB_STATS_EN
   logic [15:0]       stat_grants;
   logic [31:0]       stat_words;
`endif

   usb_fifo_drain_arbiter #(
      .NUM_PORTS(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .GAP_CYCLES(GAP)
   ) dut (
      .clk(clk), .rst(rst), .port_enable(port_enable), .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_port(out_port),
      .out_first(out_first), .busy(busy)
`ifdef USB_ARB_STATS_EN
      , .stat_grants(stat_grants), .stat_words(stat_words)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [PW-1:0] port;
      logic [DW-1:0] data;
      logic          first;
   } word_t;

   word_t         exp_q [$];
   logic [DW-1:0] fq [N][$];
   logic [DW-1:0] mq [N][$];

   int     errors = 0;
   int     checks = 0;
   int     outstanding = 0;
   int     cyc = 0;
   int     model_last = N - 1;
   int     last_acc_cyc [N];
   int     first_rd_cyc [N];
   int     rd_cnt [N];
   logic   prev_stall = 1'b0;
   word_t  prev_word;
   logic   busy_s = 1'b0;
   logic   no_repeat_en = 1'b0;
   logic   have_prev_first = 1'b0;
   logic [PW-1:0] prev_first_port = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Transaction-level reference: round robin over enabled non-empty ports, up to MB words per grant.
   task automatic model_run(input logic [N-1:0] en);
      int    pick;
      int    p;
      word_t e;
      for (int guard = 0; guard < 1000; guard++) begin
         pick = -1;
         for (int k = 1; k <= N; k++) begin
            p = (model_last + k) % N;
            if (pick < 0 && en[p] && mq[p].size() > 0) pick = p;
         end
         if (pick < 0) break;
         for (int w = 0; w < MB && mq[pick].size() > 0; w++) begin
            e.port  = PW'(pick);
            e.data  = mq[pick].pop_front();
            e.first = (w == 0);
            exp_q.push_back(e);
         end
         model_last = pick;
      end
   endtask

   task automatic load(input int p, input int n);
      logic [DW-1:0] d;
      for (int i = 0; i < n; i++) begin
         d = DW'($urandom);
         fq[p].push_back(d);
         mq[p].push_back(d);
      end
      fifo_empty[p] = (fq[p].size() == 0);
   endtask

   task automatic clear_track();
      for (int p = 0; p < N; p++) begin
         last_acc_cyc[p] = -1;
         first_rd_cyc[p] = -1;
         rd_cnt[p] = 0;
      end
   endtask

   // One clock: sample/check at negedge, then apply FIFO reads just after the posedge.
   task automatic cycle();
      logic [N-1:0] rd;
      word_t        w;
      word_t        e;
      @(negedge clk);
      cyc++;
      rd = fifo_rd_en;
      busy_s = busy;
      w.port = out_port; w.data = out_data; w.first = out_first;
      if (!rst) begin
         if (prev_stall) check("stall_hold", {out_valid, w}, {1'b1, prev_word});
         if (rd != '0) begin
            check("rd_onehot", $onehot(rd), 1);
            check("rd_gate", outstanding < 2, 1);
            check("rd_legal", rd & port_enable & ~fifo_empty, rd);
            for (int p = 0; p < N; p++) begin
               if (rd[p]) begin
                  rd_cnt[p]++;
                  if (first_rd_cyc[p] < 0) first_rd_cyc[p] = cyc;
               end
            end
         end
         if (out_valid && out_ready) begin
            check("word_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("out_word", w, e);
            end
            if (no_repeat_en && out_first) begin
               if (have_prev_first) check("no_repeat_grant", out_port != prev_first_port, 1);
               have_prev_first = 1'b1;
               prev_first_port = out_port;
            end
            last_acc_cyc[out_port] = cyc;
            outstanding--;
         end
         if (rd != '0) outstanding++;
         prev_stall = out_valid && !out_ready;
         prev_word  = w;
      end
      @(posedge clk);
      #1;
      if (!rst) begin
         for (int p = 0; p < N; p++) begin
            if (rd[p] && fq[p].size() != 0) fifo_rd_data[p*DW +: DW] = fq[p].pop_front();
         end
      end
      for (int p = 0; p < N; p++) fifo_empty[p] = (fq[p].size() == 0);
   endtask

   task automatic drain(input int budget, input logic rand_ready);
      logic done;
      done = 1'b0;
      for (int n = 0; n < budget; n++) begin
         if (rand_ready) out_ready = 1'($urandom_range(0, 1));
         cycle();
         if (exp_q.size() == 0 && outstanding == 0 && !busy_s) begin
            done = 1'b1;
            break;
         end
      end
      out_ready = 1'b1;
      check("drain_done", done, 1);
   endtask

   initial begin
      word_t e;
      logic  ok;
      rst          = 1'b1;
      port_enable  = '1;
      fifo_empty   = '1;
      fifo_rd_data = '0;
      out_ready    = 1'b1;
      prev_word    = '0;
      clear_track();

      // Reset state
      @(negedge clk);
      check("reset_outputs", {fifo_rd_en, out_valid, out_data, out_port, out_first, busy}, 0);
`ifdef USB_ARB_STATS_EN
      check("reset_stats", {stat_grants, stat_words}, 0);
`endif
      @(posedge clk);
      #1 rst = 1'b0;

      // Ports 0 and 2, three words each
      clear_track();
      load(0, 3);
      load(2, 3);
      model_run('1);
      drain(200, 1'b0);
      check("t1_gap_timing", first_rd_cyc[2] - last_acc_cyc[0], GAP + 3);
      check("t1_busy_low", busy_s, 0);
`ifdef USB_ARB_STATS_EN
      check("t1_stats", {stat_grants, stat_words}, {16'd2, 32'd6});
`endif

      // Port 1 with 10 words: bursts of 4,4,2
      clear_track();
      load(1, 10);
      model_run('1);
      drain(300, 1'b0);
      check("t2_reads", rd_cnt[1], 10);

      // 20 words under random backpressure
      clear_track();
      load(3, 20);
      model_run('1);
      drain(800, 1'b1);
      check("t3_reads", rd_cnt[3], 20);

      // All ports loaded: strict rotation
      clear_track();
      for (int p = 0; p < N; p++) load(p, 8);
      no_repeat_en = 1'b1;
      have_prev_first = 1'b0;
      model_run('1);
      drain(800, 1'b0);
      no_repeat_en = 1'b0;

      // Enable dropped after three reads from the granted port
      clear_track();
      load(1, 8);
      load(2, 2);
      for (int i = 0; i < 3; i++) begin
         e.port = PW'(1); e.data = mq[1].pop_front(); e.first = (i == 0);
         exp_q.push_back(e);
      end
      model_last = 1;
      for (int n = 0; n < 60 && rd_cnt[1] < 3; n++) cycle();
      port_enable[1] = 1'b0;
      check("t5_three_reads_seen", rd_cnt[1], 3);
      model_run(4'b1101);
      drain(300, 1'b0);
      check("t5_reads_total", rd_cnt[1], 3);
      check("t5_port1_left", fq[1].size(), 5);
      port_enable[1] = 1'b1;
      model_run('1);
      drain(300, 1'b0);

      // Reset with skid full
      clear_track();
      load(0, 8);
      out_ready = 1'b0;
      ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         cycle();
         if (outstanding == 2) begin
            ok = 1'b1;
            break;
         end
      end
      cycle();
      check("t6_fill_reached", ok, 1);
      check("t6_skid_valid", out_valid, 1);
      rst = 1'b1;
      #1;
      check("t6_reset_outputs", {fifo_rd_en, out_valid, out_data, out_port, out_first, busy}, 0);
`ifdef USB_ARB_STATS_EN
      check("t6_reset_stats", {stat_grants, stat_words}, 0);
`endif
      outstanding = 0;
      exp_q.delete();
      prev_stall = 1'b0;
      model_last = N - 1;
      for (int p = 0; p < N; p++) mq[p] = fq[p];
      cycle();
      rst = 1'b0;
      out_ready = 1'b1;
      clear_track();
      load(3, 2);
      model_run('1);
      drain(400, 1'b0);
      check("t6_restart_port0_first", first_rd_cyc[0] >= 0 && first_rd_cyc[0] < first_rd_cyc[3], 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
